// File: rtl/dmem_sdp_port_ctrl_pkg.sv
// rtl/dmem_sdp_port_ctrl_pkg.sv - shared types and helpers for the data-memory port
// Purpose: access-size encodings, stage-1 load record and the misalignment predicate.
// Ports: none (package).
package dmem_sdp_port_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Everything the s1->s2 transfer needs, captured when a load is accepted.
  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic        err;
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;
  } s1_t;

  // Size 11 is never legal; half needs even address, word needs 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = lane[0];
      SZ_W:    r = |lane;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_sdp_port_ctrl_if.sv
// rtl/dmem_sdp_port_ctrl_if.sv - core-side load/store bus plus RAM port bundle
// Purpose: groups the store, load-request, load-response and SDP RAM signals.
// Ports: slave  = the port controller (drives ready/response/RAM controls),
//        master = core plus RAM (drives requests, ld_ack and rddata).
interface dmem_sdp_port_ctrl_if #(
  parameter int ADDRS_WIDTH = 11
);
  logic                   st_req;
  logic [1:0]             st_size;
  logic [ADDRS_WIDTH+1:0] st_addrs;
  logic [31:0]            st_data;
  logic                   st_ready;
  logic                   st_misalign;

  logic                   ld_req;
  logic [1:0]             ld_size;
  logic                   ld_unsigned;
  logic [ADDRS_WIDTH+1:0] ld_addrs;
  logic                   ld_ready;
  logic                   ld_valid;
  logic [31:0]            ld_data;
  logic                   ld_misalign;
  logic                   ld_ack;

  logic                   wren;
  logic [3:0]             bwren;
  logic [ADDRS_WIDTH-1:0] wraddrs;
  logic [31:0]            wrdata;
  logic                   rden;
  logic [ADDRS_WIDTH-1:0] rdaddrs;
  logic [31:0]            rddata;

  modport slave (
    input  st_req, st_size, st_addrs, st_data,
    input  ld_req, ld_size, ld_unsigned, ld_addrs, ld_ack, rddata,
    output st_ready, st_misalign, ld_ready, ld_valid, ld_data, ld_misalign,
    output wren, bwren, wraddrs, wrdata, rden, rdaddrs
  );

  modport master (
    output st_req, st_size, st_addrs, st_data,
    output ld_req, ld_size, ld_unsigned, ld_addrs, ld_ack, rddata,
    input  st_ready, st_misalign, ld_ready, ld_valid, ld_data, ld_misalign,
    input  wren, bwren, wraddrs, wrdata, rden, rdaddrs
  );

endinterface

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - merges forwarded store lanes, aligns and extends load data
// Purpose: combinational s1->s2 datapath.
// Ports: i_size/i_unsigned/i_lane/i_err describe the load; i_fwd_mask/i_fwd_data are
//        same-cycle store lanes; i_rddata is the RAM word; o_data is the extended result.
module dmem_load_align
  import dmem_sdp_port_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic        i_err,
  input  logic [3:0]  i_fwd_mask,
  input  logic [31:0] i_fwd_data,
  input  logic [31:0] i_rddata,
  output logic [31:0] o_data
);

  logic [31:0] w_merged;
  logic [31:0] w_shifted;

  always_comb begin
    w_merged = i_rddata;
    // The RAM returned pre-store data for a same-cycle store; patch its lanes in.
    for (int i = 0; i < 4; i++) begin
      if (i_fwd_mask[i]) w_merged[8*i +: 8] = i_fwd_data[8*i +: 8];
    end
    w_shifted = w_merged >> {i_lane, 3'b000};
  end

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      SZ_B:    o_data = {{24{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
      SZ_H:    o_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
    if (i_err) o_data = 32'h0;
  end

endmodule

// File: rtl/dmem_sdp_port_ctrl.sv
// rtl/dmem_sdp_port_ctrl.sv - core-side data-memory port for a 32-bit SDP byte-write RAM
// Purpose: formats stores into word writes with byte enables, issues loads into a
//          2-stage response pipe with same-cycle store forwarding and misalign reporting.
// Ports: CLK, RESET (sync, active-high); bus (slave modport) carries the store/load
//        request channels, the held load response and the RAM write/read ports.
module dmem_sdp_port_ctrl
  import dmem_sdp_port_ctrl_pkg::*;
#(
  parameter int ADDRS_WIDTH = 11
) (
  input logic                 CLK,
  input logic                 RESET,
  dmem_sdp_port_ctrl_if.slave bus
);

  localparam int AW = ADDRS_WIDTH;

  logic        w_stall;
  logic        w_ready;
  logic        w_st_acc;
  logic        w_st_err;
  logic        w_ld_acc;
  logic        w_ld_err;
  logic        w_same_word;
  logic        w_s2_free;
  logic        w_s1_adv;
  logic [3:0]  w_bwren;
  logic [31:0] w_wrdata;
  logic [31:0] w_align_data;
  s1_t         w_s1_next;

  s1_t         r_s1;
  logic        r_s1_v;
  logic        r_s2_v;
  logic        r_s2_err;
  logic [31:0] r_ld_data;
  logic        r_st_mis;

  // Both pipe stages full with the head unconsumed: nothing can move, so both
  // request channels close. This also keeps the RAM output register frozen
  // (no wren/rden) while s1 waits on its read data.
  assign w_stall = r_s1_v && r_s2_v && !bus.ld_ack;
  assign w_ready = !w_stall && !RESET;

  assign bus.st_ready = w_ready;
  assign bus.ld_ready = w_ready;

  assign w_st_acc = bus.st_req && w_ready;
  assign w_st_err = is_misaligned(bus.st_size, bus.st_addrs[1:0]);
  assign w_ld_acc = bus.ld_req && w_ready;
  assign w_ld_err = is_misaligned(bus.ld_size, bus.ld_addrs[1:0]);

  // Store formatter: replicate the datum across lanes so bwren alone picks the bytes.
  always_comb begin
    w_wrdata = bus.st_data;
    w_bwren  = 4'b0000;
    case (bus.st_size)
      SZ_B: begin
        w_wrdata = {4{bus.st_data[7:0]}};
        w_bwren  = 4'b0001 << bus.st_addrs[1:0];
      end
      SZ_H: begin
        w_wrdata = {2{bus.st_data[15:0]}};
        w_bwren  = bus.st_addrs[1] ? 4'b1100 : 4'b0011;
      end
      SZ_W: begin
        w_wrdata = bus.st_data;
        w_bwren  = 4'b1111;
      end
      default: begin
        w_wrdata = bus.st_data;
        w_bwren  = 4'b0000;
      end
    endcase
  end

  assign bus.wren    = w_st_acc && !w_st_err;
  assign bus.bwren   = w_bwren & {4{bus.wren}};
  assign bus.wraddrs = bus.st_addrs[AW+1:2];
  assign bus.wrdata  = w_wrdata;

  // Misaligned loads still take a pipe slot so responses stay in order.
  assign bus.rden    = w_ld_acc && !w_ld_err;
  assign bus.rdaddrs = bus.ld_addrs[AW+1:2];

  // A store accepted alongside a load is older; the RAM returns old data on
  // the colliding edge, so its lanes are carried with the load instead.
  assign w_same_word = bus.wren && w_ld_acc &&
                       (bus.st_addrs[AW+1:2] == bus.ld_addrs[AW+1:2]);

  always_comb begin
    w_s1_next          = '0;
    w_s1_next.size     = bus.ld_size;
    w_s1_next.uns      = bus.ld_unsigned;
    w_s1_next.lane     = bus.ld_addrs[1:0];
    w_s1_next.err      = w_ld_err;
    w_s1_next.fwd_mask = w_same_word ? w_bwren : 4'b0000;
    w_s1_next.fwd_data = w_wrdata;
  end

  assign w_s2_free = !(r_s2_v && !bus.ld_ack);
  assign w_s1_adv  = r_s1_v && w_s2_free;

  dmem_load_align u_align (
    .i_size     (r_s1.size),
    .i_unsigned (r_s1.uns),
    .i_lane     (r_s1.lane),
    .i_err      (r_s1.err),
    .i_fwd_mask (r_s1.fwd_mask),
    .i_fwd_data (r_s1.fwd_data),
    .i_rddata   (bus.rddata),
    .o_data     (w_align_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1      <= '0;
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s2_err  <= 1'b0;
      r_ld_data <= 32'h0;
      r_st_mis  <= 1'b0;
    end else begin
      r_st_mis <= w_st_acc && w_st_err;

      // A load is only accepted when s1 is empty or draining this edge.
      if (w_ld_acc) begin
        r_s1_v <= 1'b1;
        r_s1   <= w_s1_next;
      end else if (w_s1_adv) begin
        r_s1_v <= 1'b0;
      end

      if (w_s1_adv) begin
        r_s2_v    <= 1'b1;
        r_s2_err  <= r_s1.err;
        r_ld_data <= w_align_data;
      end else if (bus.ld_ack) begin
        r_s2_v   <= 1'b0;
        r_s2_err <= 1'b0;
      end
    end
  end

  assign bus.ld_valid    = r_s2_v;
  assign bus.ld_misalign = r_s2_err;
  assign bus.ld_data     = r_ld_data;
  assign bus.st_misalign = r_st_mis;

endmodule

// File: tb/tb_dmem_sdp_port_ctrl.sv
// tb/tb_dmem_sdp_port_ctrl.sv - self-checking bench for dmem_sdp_port_ctrl
module tb_dmem_sdp_port_ctrl;
  import dmem_sdp_port_ctrl_pkg::*;

  localparam int AW = 11;

  logic CLK;
  logic RESET;

  dmem_sdp_port_ctrl_if #(.ADDRS_WIDTH(AW)) bus ();

  dmem_sdp_port_ctrl #(.ADDRS_WIDTH(AW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Attached SDP RAM: 1-cycle read, old data on same-edge collision.
  bit [31:0] ram [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (bus.wren || bus.rden) bus.rddata <= ram[bus.rdaddrs];
    if (bus.wren) begin
      for (int b = 0; b < 4; b++)
        if (bus.bwren[b]) ram[bus.wraddrs][8*b +: 8] <= bus.wrdata[8*b +: 8];
    end
  end

  // Reference model: byte-addressed memory plus an in-order queue of expected responses.
  typedef struct {
    logic [31:0] data;
    logic        mis;
    int          acc;
  } exp_t;

  bit [7:0] ref_mem [0:(1<<(AW+2))-1];
  exp_t     q [$];
  int       cyc;
  logic     exp_st_mis;

  int n_checks;
  int n_errors;

  logic        s_ready, s_wren, s_rden, s_st_mis, s_ld_valid, s_ld_mis;
  logic [3:0]  s_bwren;
  logic [31:0] s_wrdata, s_ld_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic tb_mis(input logic [1:0] sz, input logic [12:0] a);
    if (sz == 2'd3) return 1'b1;
    return (int'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [12:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
    if (!uns && n < 4 && v[8*n-1]) begin
      for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    end
    return v;
  endfunction

  // Drive one cycle of stimulus at posedge+1, check at the falling edge, advance.
  task automatic step(input logic sr, input logic [1:0] ssz, input logic [12:0] sa, input logic [31:0] sd,
                      input logic lr, input logic [1:0] lsz, input logic lu, input logic [12:0] la,
                      input logic ack);
    logic exp_ready, exp_valid, st_acc, ld_acc, sm, lm;
    logic [3:0]  eb;
    logic [31:0] ed;
    int lo, n;
    exp_t e;
    bus.st_req = sr; bus.st_size = ssz; bus.st_addrs = sa; bus.st_data = sd;
    bus.ld_req = lr; bus.ld_size = lsz; bus.ld_unsigned = lu; bus.ld_addrs = la;
    bus.ld_ack = ack;
    #4;
    s_ready = bus.st_ready; s_wren = bus.wren; s_rden = bus.rden; s_bwren = bus.bwren;
    s_wrdata = bus.wrdata; s_st_mis = bus.st_misalign; s_ld_valid = bus.ld_valid;
    s_ld_data = bus.ld_data; s_ld_mis = bus.ld_misalign;

    exp_ready = !(q.size() == 2 && !ack);
    check_eq("st_ready", {31'h0, bus.st_ready}, {31'h0, exp_ready});
    check_eq("ld_ready", {31'h0, bus.ld_ready}, {31'h0, exp_ready});

    exp_valid = (q.size() > 0) && (cyc - q[0].acc >= 2);
    check_eq("ld_valid", {31'h0, bus.ld_valid}, {31'h0, exp_valid});
    if (exp_valid) begin
      check_eq("ld_data", bus.ld_data, q[0].data);
      check_eq("ld_misalign", {31'h0, bus.ld_misalign}, {31'h0, q[0].mis});
      if (ack) void'(q.pop_front());
    end
    check_eq("st_misalign", {31'h0, bus.st_misalign}, {31'h0, exp_st_mis});

    st_acc = sr && exp_ready;
    sm = tb_mis(ssz, sa);
    check_eq("wren", {31'h0, bus.wren}, {31'h0, st_acc && !sm});
    if (st_acc && !sm) begin
      n  = nbytes(ssz);
      lo = int'(sa[1:0]);
      eb = 4'h0;
      for (int b = 0; b < 4; b++) begin
        eb[b] = (b >= lo) && (b < lo + n);
        ed[8*b +: 8] = sd[8*(b % n) +: 8];
      end
      check_eq("wraddrs", {21'h0, bus.wraddrs}, {21'h0, sa[12:2]});
      check_eq("bwren", {28'h0, bus.bwren}, {28'h0, eb});
      check_eq("wrdata", bus.wrdata, ed);
      for (int k = 0; k < n; k++) ref_mem[int'(sa) + k] = sd[8*k +: 8];
    end
    exp_st_mis = st_acc && sm;

    ld_acc = lr && exp_ready;
    lm = tb_mis(lsz, la);
    check_eq("rden", {31'h0, bus.rden}, {31'h0, ld_acc && !lm});
    if (ld_acc && !lm) check_eq("rdaddrs", {21'h0, bus.rdaddrs}, {21'h0, la[12:2]});
    if (ld_acc) begin
      e.data = lm ? 32'h0 : ref_load(lsz, lu, la);
      e.mis  = lm;
      e.acc  = cyc;
      q.push_back(e);
    end
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic idle(input logic ack);
    step(1'b0, SZ_W, 13'h0, 32'h0, 1'b0, SZ_W, 1'b0, 13'h0, ack);
  endtask

  // Reset with requests held high: nothing may issue, the pipe must empty.
  task automatic do_reset(input int n);
    RESET = 1'b1;
    bus.st_req = 1'b1; bus.st_size = SZ_W; bus.st_addrs = 13'h10; bus.st_data = 32'hDEADBEEF;
    bus.ld_req = 1'b1; bus.ld_size = SZ_W; bus.ld_unsigned = 1'b0; bus.ld_addrs = 13'h10;
    bus.ld_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      #4;
      check_eq("rst_st_ready", {31'h0, bus.st_ready}, 32'h0);
      check_eq("rst_ld_ready", {31'h0, bus.ld_ready}, 32'h0);
      check_eq("rst_wren", {31'h0, bus.wren}, 32'h0);
      check_eq("rst_rden", {31'h0, bus.rden}, 32'h0);
      if (i > 0) begin
        check_eq("rst_ld_valid", {31'h0, bus.ld_valid}, 32'h0);
        check_eq("rst_ld_data", bus.ld_data, 32'h0);
        check_eq("rst_ld_misalign", {31'h0, bus.ld_misalign}, 32'h0);
        check_eq("rst_st_misalign", {31'h0, bus.st_misalign}, 32'h0);
      end
      @(posedge CLK); #1;
      cyc++;
    end
    RESET = 1'b0;
    bus.st_req = 1'b0; bus.ld_req = 1'b0;
    q.delete();
    exp_st_mis = 1'b0;
  endtask

  initial begin
    logic [12:0] sa, la;
    logic [1:0]  ssz, lsz;
    n_checks = 0; n_errors = 0; cyc = 0; exp_st_mis = 1'b0;
    RESET = 1'b1;
    bus.st_req = 1'b0; bus.st_size = SZ_B; bus.st_addrs = '0; bus.st_data = '0;
    bus.ld_req = 1'b0; bus.ld_size = SZ_B; bus.ld_unsigned = 1'b0; bus.ld_addrs = '0;
    bus.ld_ack = 1'b0;
    @(posedge CLK); #1;
    do_reset(3);

    // 1: SB then LBU, two-cycle latency
    step(1'b1, SZ_B, 13'h006, 32'h000000A5, 1'b0, SZ_B, 1'b0, 13'h0, 1'b1);
    check_eq("t1_bwren", {28'h0, s_bwren}, 32'h4);
    check_eq("t1_wrdata", s_wrdata, 32'hA5A5A5A5);
    step(1'b0, SZ_B, 13'h0, 32'h0, 1'b1, SZ_B, 1'b1, 13'h006, 1'b1);
    idle(1'b1);
    check_eq("t1_valid_n1", {31'h0, s_ld_valid}, 32'h0);
    idle(1'b1);
    check_eq("t1_valid_n2", {31'h0, s_ld_valid}, 32'h1);
    check_eq("t1_data", s_ld_data, 32'h000000A5);

    // 2: SH then LH / LHU
    step(1'b1, SZ_H, 13'h00A, 32'h00008001, 1'b0, SZ_B, 1'b0, 13'h0, 1'b1);
    check_eq("t2_bwren", {28'h0, s_bwren}, 32'hC);
    step(1'b0, SZ_B, 13'h0, 32'h0, 1'b1, SZ_H, 1'b0, 13'h00A, 1'b1);
    step(1'b0, SZ_B, 13'h0, 32'h0, 1'b1, SZ_H, 1'b1, 13'h00A, 1'b1);
    idle(1'b1);
    check_eq("t2_lh", s_ld_data, 32'hFFFF8001);
    idle(1'b1);
    check_eq("t2_lhu", s_ld_data, 32'h00008001);

    // 3: same-cycle store->load forwarding
    step(1'b1, SZ_W, 13'h000, 32'h11223344, 1'b0, SZ_B, 1'b0, 13'h0, 1'b1);
    step(1'b1, SZ_B, 13'h001, 32'h000000EE, 1'b1, SZ_W, 1'b0, 13'h000, 1'b1);
    step(1'b0, SZ_B, 13'h0, 32'h0, 1'b1, SZ_W, 1'b0, 13'h000, 1'b1);
    idle(1'b1);
    check_eq("t3_fwd", s_ld_data, 32'h1122EE44);
    idle(1'b1);
    check_eq("t3_ram", s_ld_data, 32'h1122EE44);

    // 4: misaligned load and store
    step(1'b1, SZ_H, 13'h003, 32'h0000BEEF, 1'b1, SZ_W, 1'b0, 13'h002, 1'b1);
    check_eq("t4_rden", {31'h0, s_rden}, 32'h0);
    check_eq("t4_wren", {31'h0, s_wren}, 32'h0);
    idle(1'b1);
    check_eq("t4_st_mis", {31'h0, s_st_mis}, 32'h1);
    idle(1'b1);
    check_eq("t4_ld_valid", {31'h0, s_ld_valid}, 32'h1);
    check_eq("t4_ld_mis", {31'h0, s_ld_mis}, 32'h1);
    check_eq("t4_ld_data", s_ld_data, 32'h0);
    idle(1'b1);
    check_eq("t4_st_mis_pulse", {31'h0, s_st_mis}, 32'h0);

    // 5: back-pressure with three loads
    step(1'b1, SZ_W, 13'h004, 32'hAAAA5555, 1'b0, SZ_B, 1'b0, 13'h0, 1'b1);
    step(1'b1, SZ_W, 13'h008, 32'h0BADF00D, 1'b0, SZ_B, 1'b0, 13'h0, 1'b1);
    step(1'b0, SZ_B, 13'h0, 32'h0, 1'b1, SZ_W, 1'b0, 13'h000, 1'b0);
    step(1'b0, SZ_B, 13'h0, 32'h0, 1'b1, SZ_W, 1'b0, 13'h004, 1'b0);
    step(1'b1, SZ_W, 13'h00C, 32'h55555555, 1'b1, SZ_W, 1'b0, 13'h008, 1'b0);
    check_eq("t5_ready_full", {31'h0, s_ready}, 32'h0);
    check_eq("t5_st_blocked", {31'h0, s_wren}, 32'h0);
    step(1'b0, SZ_B, 13'h0, 32'h0, 1'b1, SZ_W, 1'b0, 13'h008, 1'b0);
    step(1'b0, SZ_B, 13'h0, 32'h0, 1'b1, SZ_W, 1'b0, 13'h008, 1'b1);
    check_eq("t5_ready_ack", {31'h0, s_ready}, 32'h1);
    check_eq("t5_resp0", s_ld_data, 32'h1122EE44);
    idle(1'b1);
    check_eq("t5_resp1", s_ld_data, 32'hAAAA5555);
    idle(1'b1);
    check_eq("t5_resp2", s_ld_data, 32'h0BADF00D);
    idle(1'b1);

    // 6: reset with two loads in flight
    step(1'b0, SZ_B, 13'h0, 32'h0, 1'b1, SZ_W, 1'b0, 13'h000, 1'b1);
    step(1'b0, SZ_B, 13'h0, 32'h0, 1'b1, SZ_W, 1'b0, 13'h004, 1'b1);
    do_reset(2);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomized traffic over a few words to provoke collisions and stalls.
    for (int i = 0; i < 400; i++) begin
      ssz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      lsz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sa  = 13'($urandom_range(0, 31));
      la  = 13'($urandom_range(0, 31));
      if ($urandom_range(0, 4) != 0) begin
        if (ssz == SZ_H) sa[0] = 1'b0;
        if (ssz == SZ_W) sa[1:0] = 2'b00;
        if (lsz == SZ_H) la[0] = 1'b0;
        if (lsz == SZ_W) la[1:0] = 2'b00;
      end
      step(1'($urandom_range(0, 1)), ssz, sa, $urandom,
           1'($urandom_range(0, 2) != 0), lsz, 1'($urandom_range(0, 1)), la,
           1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_eq("drain_empty", q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
